coef_load_ctrl: RTL

- Sequencer that accepts a coefficient stream over a valid/ready handshake and scatters it across NBANK coefficient BRAM banks, interleaved by index.
- Writes go to the inactive half (page) of each bank.
- After a complete, correctly sized load, switches the read page atomically on the next filter-frame boundary pulse.
- Sits between the configuration/DMA interface and the coefficient banks of the time-multiplexed FIR.

---
 rtl/coef_load_ctrl.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/coef_load_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : coef_load_ctrl
//  Description : Coefficient load sequencer. Accepts a valid/ready stream of
//                signed coefficients and scatters them round-robin across
//                NBANK BRAM banks, always into the page that the read side is
//                not using. After a load of exactly NCOEF beats it holds off
//                the stream and flips the read page on the next frame-boundary
//                pulse.
//  Ports       : clk, rstn            - clock, async active-low reset
//                s_valid/s_ready      - stream handshake
//                s_data, s_last       - coefficient and end-of-load marker
//                swap_sync            - frame-boundary pulse
//                coef_write*          - registered bank write port (shared
//                                       data/address, one-hot enable)
//                rd_page              - page the read side must use
//                busy, err, load_count- status
//  Revision    : 1.0 - initial release
// ============================================================================
module coef_load_ctrl #(
   parameter int COEFW = 18,
   parameter int AW    = 7,
   parameter int NBANK = 4,
   parameter int NCOEF = 200,
   parameter int CNTW  = 9
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic               s_valid,
   output logic               s_ready,
   input  logic [COEFW-1:0]   s_data,
   input  logic               s_last,
   input  logic               swap_sync,
   output logic [COEFW-1:0]   coef_write,
   output logic [AW-1:0]      coef_write_addr,
   output logic [NBANK-1:0]   coef_write_en,
   output logic               rd_page,
   output logic               busy,
   output logic               err,
   output logic [CNTW-1:0]    load_count
);

   localparam int            BW         = (NBANK > 1) ? $clog2(NBANK) : 1;
   localparam logic [CNTW-1:0] C_NCOEF  = CNTW'(NCOEF);
   localparam logic [CNTW-1:0] C_NBANK  = CNTW'(NBANK);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      DRAIN = 2'd2,
      ARMED = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic               ready_q, ready_d;
   logic [COEFW-1:0]   wdata_q, wdata_d;
   logic [AW-1:0]      waddr_q, waddr_d;
   logic [NBANK-1:0]   wen_q,   wen_d;
   logic               rd_page_q, rd_page_d;
   logic               err_q,   err_d;
   logic [CNTW-1:0]    cnt_q,   cnt_d;

   logic               w_acc;
   logic [CNTW-1:0]    w_idx;
   logic [CNTW-1:0]    w_n;
   logic [BW-1:0]      w_bank;
   logic [AW-2:0]      w_word;

   // ready is registered so it is low throughout reset and rises on the
   // first edge after release.
   assign w_acc  = s_valid & ready_q;
   // A beat taken in IDLE always starts a fresh load at index 0, whatever
   // load_count was left at by an aborted load.
   assign w_idx  = (state_q == IDLE) ? '0 : cnt_q;
   assign w_n    = w_idx + CNTW'(1);
   assign w_bank = BW'(w_idx % C_NBANK);
   assign w_word = (AW-1)'(w_idx / C_NBANK);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= IDLE;
         ready_q   <= 1'b0;
         wdata_q   <= '0;
         waddr_q   <= '0;
         wen_q     <= '0;
         rd_page_q <= 1'b0;
         err_q     <= 1'b0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         ready_q   <= ready_d;
         wdata_q   <= wdata_d;
         waddr_q   <= waddr_d;
         wen_q     <= wen_d;
         rd_page_q <= rd_page_d;
         err_q     <= err_d;
         cnt_q     <= cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      wdata_d   = wdata_q;
      waddr_d   = waddr_q;
      wen_d     = '0;
      rd_page_d = rd_page_q;
      err_d     = err_q;
      cnt_d     = cnt_q;

      case (state_q)
         IDLE, LOAD: begin
            if (w_acc) begin
               if (state_q == IDLE) begin
                  err_d = 1'b0;
               end
               wdata_d = s_data;
               waddr_d = {~rd_page_q, w_word};
               wen_d   = NBANK'(1) << w_bank;
               cnt_d   = w_n;
               state_d = LOAD;
               if (s_last) begin
                  if (w_n == C_NCOEF) begin
                     state_d = ARMED;
                  end else begin
                     err_d   = 1'b1;
                     state_d = IDLE;
                  end
               end else if (w_n == C_NCOEF) begin
                  // Overlong load: this beat is the last one written; the
                  // rest of the stream is swallowed until s_last.
                  err_d   = 1'b1;
                  state_d = DRAIN;
               end
            end
         end
         DRAIN: begin
            // load_count stays at NCOEF: discarded beats are not counted.
            if (w_acc && s_last) begin
               state_d = IDLE;
            end
         end
         ARMED: begin
            // Only a pulse seen while already ARMED counts, so the final
            // write has always landed before the page flips.
            if (swap_sync) begin
               rd_page_d = ~rd_page_q;
               cnt_d     = '0;
               state_d   = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      ready_d = (state_d != ARMED);
   end

   assign s_ready         = ready_q;
   assign coef_write      = wdata_q;
   assign coef_write_addr = waddr_q;
   assign coef_write_en   = wen_q;
   assign rd_page         = rd_page_q;
   assign busy            = (state_q != IDLE);
   assign err             = err_q;
   assign load_count      = cnt_q;

endmodule
`default_nettype wire
